// File: rtl/sig_dump_ctrl.sv
// ============================================================================
//  Module   : sig_dump_ctrl
//  Purpose  : CPU-bus register window that halts the test and streams the
//             signature memory range out over a valid/ready interface.
//             Optional checksum trailer word: define SIG_DUMP_CHECKSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sig_dump_ctrl #(
  parameter logic [31:0] BASE   = 32'h2000_0000,
  parameter int          ADDR_W = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_load,
  input  logic              mem_store,
  input  logic [31:0]       address,
  input  logic [31:0]       store_data,
  output logic              sel,
  output logic [31:0]       load_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              sig_valid,
  output logic [31:0]       sig_data,
  output logic              sig_last,
  input  logic              sig_ready,
  output logic              halted,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_FIN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] OFF_CTRL  = 2'd0;
  localparam logic [1:0] OFF_BEGIN = 2'd1;
  localparam logic [1:0] OFF_END   = 2'd2;
  localparam logic [1:0] OFF_COUNT = 2'd3;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   begin_q, begin_d;
  logic [ADDR_W-1:0]   end_q,   end_d;
  logic [ADDR_W-1:0]   ptr_q,   ptr_d;
  logic [31:0]         count_q, count_d;
  logic [31:0]         data_q,  data_d;
  logic                halted_q, halted_d;
`ifdef SIG_DUMP_CHECKSUM_EN
  logic [31:0]         csum_q,  csum_d;
`endif

  logic [1:0]          offset;
  logic                reg_wr;
  logic                reg_rd;
  logic                halt_req;
  logic                busy;
  logic [ADDR_W-1:0]   ptr_inc;
  logic                last_word;
  logic                unused_addr_lsb;

  // Byte lanes within a word carry no meaning for this register file.
  assign unused_addr_lsb = ^address[1:0];

  assign sel       = (address[31:4] == BASE[31:4]);
  assign offset    = address[3:2];
  assign reg_wr    = sel && mem_store;
  assign reg_rd    = sel && mem_load;
  assign halt_req  = reg_wr && (offset == OFF_CTRL) && (store_data == 32'd1);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign ptr_inc   = ptr_q + ADDR_W'(1);
  assign last_word = (ptr_inc == end_q);

  always_comb begin
    load_data = 32'd0;
    if (reg_rd) begin
      case (offset)
        OFF_CTRL:  load_data = {30'd0, done, busy};
        OFF_BEGIN: load_data = 32'({begin_q, 2'b00});
        OFF_END:   load_data = 32'({end_q, 2'b00});
        OFF_COUNT: load_data = count_q;
        default:   load_data = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    begin_d  = begin_q;
    end_d    = end_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    halted_d = halted_q;
`ifdef SIG_DUMP_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    // Range registers are frozen once the dump has been requested.
    if (state_q == S_IDLE && reg_wr) begin
      if (offset == OFF_BEGIN) begin
        begin_d = store_data[ADDR_W+1:2];
      end
      if (offset == OFF_END) begin
        end_d = store_data[ADDR_W+1:2];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (halt_req) begin
          halted_d = 1'b1;
          ptr_d    = begin_q;
          state_d  = (begin_q < end_q) ? S_FETCH : S_FIN;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        data_d  = rd_data;
`ifdef SIG_DUMP_CHECKSUM_EN
        csum_d  = csum_q + rd_data;
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        if (sig_ready) begin
          count_d = count_q + 32'd1;
          ptr_d   = ptr_inc;
          state_d = last_word ? S_FIN : S_FETCH;
        end
      end
      S_FIN: begin
`ifdef SIG_DUMP_CHECKSUM_EN
        if (sig_ready) begin
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
`endif
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      begin_q  <= '0;
      end_q    <= '0;
      ptr_q    <= '0;
      count_q  <= '0;
      data_q   <= '0;
      halted_q <= 1'b0;
`ifdef SIG_DUMP_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      begin_q  <= begin_d;
      end_q    <= end_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      halted_q <= halted_d;
`ifdef SIG_DUMP_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign rd_en   = (state_q == S_FETCH);
  assign rd_addr = ptr_q;
  assign halted  = halted_q;
  assign done    = (state_q == S_DONE);

`ifdef SIG_DUMP_CHECKSUM_EN
  // The trailer word carries the running sum; only it is flagged last.
  assign sig_valid = (state_q == S_SEND) || (state_q == S_FIN);
  assign sig_data  = (state_q == S_FIN) ? csum_q : data_q;
  assign sig_last  = (state_q == S_FIN);
`else
  assign sig_valid = (state_q == S_SEND);
  assign sig_data  = data_q;
  assign sig_last  = (state_q == S_SEND) && last_word;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sig_dump_ctrl.sv
// ============================================================================
//  Module   : tb_sig_dump_ctrl
//  Purpose  : Self-checking bench for sig_dump_ctrl with a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sig_dump_ctrl;

  localparam logic [31:0] BASE = 32'h2000_0000;
`ifdef SIG_DUMP_CHECKSUM_EN
  localparam int CSUM_WORDS = 1;
`else
  localparam int CSUM_WORDS = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_load = 1'b0;
  logic        mem_store = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        sel;
  logic [31:0] load_data;
  logic        rd_en;
  logic [29:0] rd_addr;
  logic [31:0] rd_data = 32'd0;
  logic        sig_valid;
  logic [31:0] sig_data;
  logic        sig_last;
  logic        sig_ready = 1'b1;
  logic        halted;
  logic        done;

  sig_dump_ctrl #(.BASE(BASE), .ADDR_W(30)) dut (
    .clock(clock), .reset(reset), .mem_load(mem_load), .mem_store(mem_store),
    .address(address), .store_data(store_data), .sel(sel), .load_data(load_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .sig_valid(sig_valid), .sig_data(sig_data), .sig_last(sig_last),
    .sig_ready(sig_ready), .halted(halted), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr[9:0]];

  // Model: expected stream queue built from memory when the halt lands.
  logic [31:0] exp_q[$];
  logic [29:0] m_begin = '0;
  logic [29:0] m_end = '0;
  bit          m_halted = 1'b0;
  int          m_count = 0;
  int          n_hs = 0;
  logic [31:0] last_word = 32'd0;
  logic [31:0] hold_data = 32'd0;
  bit          hold_last = 1'b0;
  bit          hold_pending = 1'b0;
  int          ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_halt();
    logic [31:0] sum;
    sum = 32'd0;
    if (m_halted) return;
    m_halted = 1'b1;
    if (m_begin < m_end) begin
      for (logic [29:0] a = m_begin; a != m_end; a++) begin
        exp_q.push_back(mem[a[9:0]]);
        sum += mem[a[9:0]];
      end
    end
    if (CSUM_WORDS == 1) exp_q.push_back(sum);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
    @(negedge clock);
    address = BASE | 32'(off);
    store_data = data;
    mem_store = 1'b1;
    @(posedge clock);
    if (!m_halted) begin
      case (off)
        4'h0: if (data == 32'd1) model_halt();
        4'h4: m_begin = data[31:2];
        4'h8: m_end = data[31:2];
        default: ;
      endcase
    end
    #1 mem_store = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] off, input logic [31:0] exp, input string name);
    @(negedge clock);
    address = BASE | 32'(off);
    mem_load = 1'b1;
    #1;
    check({name, "_sel"}, sel, 1'b1);
    check(name, load_data, exp);
    @(posedge clock);
    #1 mem_load = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
    check("done_reached", done, 1'b1);
  endtask

  initial begin
    int c = 0;
    forever begin
      @(negedge clock);
      c++;
      sig_ready = (ready_mode == 0) ? 1'b1 : ((c % 3) == 0);
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_halted = 1'b0;
      m_begin = '0;
      m_end = '0;
      m_count = 0;
      hold_pending = 1'b0;
    end else begin
      hold_pending = sig_valid && !sig_ready;
      hold_data = sig_data;
      hold_last = sig_last;
      if (sig_valid && sig_ready) begin
        n_hs++;
        if (sig_last) last_word = sig_data;
        if (exp_q.size() > CSUM_WORDS) m_count++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("halted", halted, m_halted);
      if (sig_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", sig_valid, 1'b0);
        end else begin
          check("sig_data", sig_data, exp_q[0]);
          check("sig_last", sig_last, exp_q.size() == 1);
        end
      end else begin
        check("sig_last_idle", sig_last, 1'b0);
      end
      if (hold_pending) begin
        check("hold_valid", sig_valid, 1'b1);
        check("hold_data", sig_data, hold_data);
        check("hold_last", sig_last, hold_last);
      end
      if (done) check("done_drained", exp_q.size(), 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int hs0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + 32'(i * 7);
    for (int i = 0; i < 4; i++) mem[16'h40 + i] = 32'(i + 1);
    repeat (2) @(posedge clock);
    do_reset();

    // Reset state
    bus_read(4'h0, 32'd0, "rst_ctrl");
    bus_read(4'h4, 32'd0, "rst_begin");
    bus_read(4'h8, 32'd0, "rst_end");
    bus_read(4'hC, 32'd0, "rst_count");
    check("rst_sig_valid", sig_valid, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clock);
    address = BASE + 32'd16;
    mem_load = 1'b1;
    #1;
    check("miss_sel", sel, 1'b0);
    check("miss_load_data", load_data, 32'd0);
    mem_load = 1'b0;

    // Simultaneous load/store returns the pre-store value
    @(negedge clock);
    address = BASE | 32'h4;
    store_data = 32'h100;
    mem_load = 1'b1;
    mem_store = 1'b1;
    #1 check("rw_pre_value", load_data, 32'd0);
    @(posedge clock);
    m_begin = 30'h40;
    #1;
    mem_load = 1'b0;
    mem_store = 1'b0;
    bus_read(4'h4, 32'h100, "rw_post_value");

    // Basic dump, ready held high
    bus_write(4'h8, 32'h110);
    hs0 = n_hs;
    bus_write(4'h0, 32'd1);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!sig_valid && cyc < 10);
    check("first_valid_latency", cyc, 3);
    wait_done(100, cyc);
    check("basic_handshakes", n_hs - hs0, 4 + CSUM_WORDS);
    check("basic_last_word", last_word, (CSUM_WORDS == 1) ? 32'd10 : 32'd4);
    bus_read(4'hC, 32'd4, "basic_count");
    bus_read(4'h0, 32'd2, "basic_ctrl_done");
    bus_write(4'h0, 32'd1);
    repeat (4) @(negedge clock);
    check("done_ignores_halt", n_hs - hs0, 4 + CSUM_WORDS);

    // Backpressure: ready 1 of 3 cycles
    do_reset();
    ready_mode = 1;
    bus_write(4'h4, 32'h100);
    bus_write(4'h8, 32'h110);
    hs0 = n_hs;
    bus_write(4'h0, 32'd1);
    wait_done(200, cyc);
    ready_mode = 0;
    check("bp_handshakes", n_hs - hs0, 4 + CSUM_WORDS);
    bus_read(4'hC, 32'd4, "bp_count");

    // Empty range
    do_reset();
    bus_write(4'h4, 32'h200);
    bus_write(4'h8, 32'h200);
    hs0 = n_hs;
    bus_write(4'h0, 32'd1);
    wait_done(20, cyc);
    if (CSUM_WORDS == 0) check("empty_done_cycles", cyc, 2);
    check("empty_handshakes", n_hs - hs0, CSUM_WORDS);
    check("empty_last_word", last_word, (CSUM_WORDS == 1) ? 32'd0 : last_word);
    bus_read(4'hC, 32'd0, "empty_count");

    // Ignored CTRL value, frozen BEGIN, repeated halt
    do_reset();
    bus_write(4'h4, 32'h300);
    bus_write(4'h8, 32'h30C);
    bus_write(4'h0, 32'd2);
    bus_read(4'h0, 32'd0, "ctrl2_ignored");
    hs0 = n_hs;
    bus_write(4'h0, 32'd1);
    bus_write(4'h4, 32'h400);
    bus_write(4'h0, 32'd1);
    bus_read(4'h4, 32'h300, "begin_frozen");
    wait_done(100, cyc);
    check("ignore_handshakes", n_hs - hs0, 3 + CSUM_WORDS);
    bus_read(4'hC, 32'(m_count), "ignore_count");

    // Reset in the middle of a dump
    do_reset();
    bus_write(4'h4, 32'h100);
    bus_write(4'h8, 32'h110);
    hs0 = n_hs;
    bus_write(4'h0, 32'd1);
    cyc = 0;
    while (n_hs - hs0 < 2 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("mid_two_handshakes", n_hs - hs0, 2);
    do_reset();
    @(negedge clock);
    check("mid_sig_valid", sig_valid, 1'b0);
    check("mid_halted", halted, 1'b0);
    bus_read(4'hC, 32'd0, "mid_count");
    bus_read(4'h0, 32'd0, "mid_ctrl");
    bus_read(4'h4, 32'd0, "mid_begin");
    bus_write(4'h8, 32'h8);
    hs0 = n_hs;
    bus_write(4'h0, 32'd1);
    wait_done(100, cyc);
    check("restart_handshakes", n_hs - hs0, 2 + CSUM_WORDS);
    bus_read(4'hC, 32'd2, "restart_count");

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
